// File: rtl/status_flags.sv
// 6502 processor status register (P): flag updates from the ALU, BIT, stack loads,
// set/clear ops and interrupt entry, plus the one-instruction-delayed IRQ mask.
module status_flags #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] upd_sel,
    input  logic [7:0] flag_mask,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    input  logic [7:0] acc,
    input  logic [7:0] mem_data,
    input  logic [7:0] load_data,
    input  logic [2:0] flag_idx,
    input  logic       push_brk,
    input  logic       instr_end,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       carry_to_alu,
    output logic       decimal,
    output logic       irq_mask
);

    typedef enum logic [2:0] {
        UPD_NONE = 3'd0,
        UPD_ALU  = 3'd1,
        UPD_BIT  = 3'd2,
        UPD_LOAD = 3'd3,
        UPD_SET  = 3'd4,
        UPD_CLR  = 3'd5,
        UPD_INTR = 3'd6,
        UPD_NOP7 = 3'd7
    } upd_e;

    localparam int BIT_C = 0;
    localparam int BIT_Z = 1;
    localparam int BIT_I = 2;
    localparam int BIT_D = 3;
    localparam int BIT_V = 6;
    localparam int BIT_N = 7;

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic irq_mask_q, irq_mask_d;
    logic flag_val;
    upd_e sel;

    assign sel = upd_e'(upd_sel);

    // SET writes a 1, CLR writes a 0; the target is picked by flag_idx
    assign flag_val = (sel == UPD_SET);

    always_comb begin
        n_d = n_q;
        v_d = v_q;
        d_d = d_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;
        unique case (sel)
            UPD_ALU: begin
                if (flag_mask[BIT_N]) n_d = alu_out[7];
                if (flag_mask[BIT_V]) v_d = alu_ovf;
                if (flag_mask[BIT_Z]) z_d = (alu_out == 8'h00);
                if (flag_mask[BIT_C]) c_d = alu_carry;
            end
            UPD_BIT: begin
                n_d = mem_data[7];
                v_d = mem_data[6];
                z_d = ((acc & mem_data) == 8'h00);
            end
            UPD_LOAD: begin
                n_d = load_data[BIT_N];
                v_d = load_data[BIT_V];
                d_d = load_data[BIT_D];
                i_d = load_data[BIT_I];
                z_d = load_data[BIT_Z];
                c_d = load_data[BIT_C];
            end
            UPD_SET, UPD_CLR: begin
                // Indices 4 and 5 address the constant B/unused bits: silently ignored
                unique case (flag_idx)
                    3'd7:    n_d = flag_val;
                    3'd6:    v_d = flag_val;
                    3'd3:    d_d = flag_val;
                    3'd2:    i_d = flag_val;
                    3'd1:    z_d = flag_val;
                    3'd0:    c_d = flag_val;
                    default: ;
                endcase
            end
            UPD_INTR: begin
                i_d = 1'b1;
            end
            UPD_NONE, UPD_NOP7: ;
            default: ;
        endcase
    end

    // irq_mask samples I before this edge's update, giving the 6502 one-instruction lag
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (sel == UPD_INTR) begin
            irq_mask_d = 1'b1;
        end else if (instr_end) begin
            irq_mask_d = i_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= RESET_P[BIT_N];
            v_q        <= RESET_P[BIT_V];
            d_q        <= RESET_P[BIT_D];
            i_q        <= RESET_P[BIT_I];
            z_q        <= RESET_P[BIT_Z];
            c_q        <= RESET_P[BIT_C];
            irq_mask_q <= 1'b1;
        end else begin
            n_q        <= n_d;
            v_q        <= v_d;
            d_q        <= d_d;
            i_q        <= i_d;
            z_q        <= z_d;
            c_q        <= c_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign p_out        = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
    assign p_push       = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
    assign carry_to_alu = c_q;
    assign decimal      = d_q;
    assign irq_mask     = irq_mask_q;

endmodule

// File: tb/tb_status_flags.sv
// Self-checking bench for status_flags: directed vector table, hand-written
// reset/push sequences, and randomized traffic against a byte-level model of P.
module tb_status_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] upd_sel;
    logic [7:0] flag_mask;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_ovf;
    logic [7:0] acc;
    logic [7:0] mem_data;
    logic [7:0] load_data;
    logic [2:0] flag_idx;
    logic       push_brk;
    logic       instr_end;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry_to_alu;
    logic       decimal;
    logic       irq_mask;

    int errors = 0;
    int checks = 0;

    status_flags #(.RESET_P(8'h24)) dut (
        .clk(clk), .rst_n(rst_n), .upd_sel(upd_sel), .flag_mask(flag_mask),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_ovf(alu_ovf), .acc(acc),
        .mem_data(mem_data), .load_data(load_data), .flag_idx(flag_idx),
        .push_brk(push_brk), .instr_end(instr_end), .p_out(p_out), .p_push(p_push),
        .carry_to_alu(carry_to_alu), .decimal(decimal), .irq_mask(irq_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] mask;
        logic [7:0] aluo;
        logic       carry;
        logic       ovf;
        logic [7:0] a;
        logic [7:0] mem;
        logic [7:0] ld;
        logic [2:0] idx;
        logic       ie;
        logic [7:0] exp_p;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] sel, logic [7:0] mask, logic [7:0] aluo,
                                logic carry, logic ovf, logic [7:0] a, logic [7:0] mem,
                                logic [7:0] ld, logic [2:0] idx, logic ie,
                                logic [7:0] exp_p, logic exp_irq);
        vec_t v;
        v.sel = sel; v.mask = mask; v.aluo = aluo; v.carry = carry; v.ovf = ovf;
        v.a = a; v.mem = mem; v.ld = ld; v.idx = idx; v.ie = ie;
        v.exp_p = exp_p; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        upd_sel = 3'd0; flag_mask = 8'h00; alu_out = 8'h00; alu_carry = 1'b0;
        alu_ovf = 1'b0; acc = 8'h00; mem_data = 8'h00; load_data = 8'h00;
        flag_idx = 3'd0; push_brk = 1'b0; instr_end = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        upd_sel = v.sel; flag_mask = v.mask; alu_out = v.aluo; alu_carry = v.carry;
        alu_ovf = v.ovf; acc = v.a; mem_data = v.mem; load_data = v.ld;
        flag_idx = v.idx; instr_end = v.ie;
        @(posedge clk);
        #1;
    endtask

    // Reference model: P kept as a byte; bit5 forced 1, bit4 forced 0
    logic [7:0] m_p;
    logic       m_irq;

    task automatic model_step(input logic [2:0] sel, input logic [7:0] mask,
                              input logic [7:0] aluo, input logic carry, input logic ovf,
                              input logic [7:0] a, input logic [7:0] mem,
                              input logic [7:0] ld, input logic [2:0] idx, input logic ie);
        logic old_i;
        old_i = m_p[2];
        case (sel)
            3'd1: begin
                if (mask[7]) m_p[7] = aluo[7];
                if (mask[6]) m_p[6] = ovf;
                if (mask[1]) m_p[1] = (aluo == 0);
                if (mask[0]) m_p[0] = carry;
            end
            3'd2: begin
                m_p[7] = mem[7];
                m_p[6] = mem[6];
                m_p[1] = ((a & mem) == 0);
            end
            3'd3: m_p = (ld & 8'hCF) | 8'h20;
            3'd4: if (idx != 4 && idx != 5) m_p[idx] = 1'b1;
            3'd5: if (idx != 4 && idx != 5) m_p[idx] = 1'b0;
            3'd6: m_p[2] = 1'b1;
            default: ;
        endcase
        if (sel == 3'd6) m_irq = 1'b1;
        else if (ie) m_irq = old_i;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_p", p_out, 8'h24);
        chk("reset_irq", {7'd0, irq_mask}, 8'h01);
        chk("reset_carry", {7'd0, carry_to_alu}, 8'h00);
        chk("reset_dec", {7'd0, decimal}, 8'h00);
        rst_n = 1'b1;

        // Build a non-reset state, then assert reset in the middle of an ALU update
        apply(mk(3'd3, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hC3, 3'd0, 1'b1, 8'hE3, 1'b1));
        chk("pre_reset_p", p_out, 8'hE3);
        upd_sel = 3'd1; flag_mask = 8'hFF; alu_out = 8'h80; alu_carry = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_p", p_out, 8'h24);
        chk("midreset_irq", {7'd0, irq_mask}, 8'h01);
        @(posedge clk);
        #1;
        chk("held_reset_p", p_out, 8'h24);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_p", p_out, 8'h24);
        chk("release_irq", {7'd0, irq_mask}, 8'h01);

        // Directed table, starting from P=24, irq_mask=1
        vecs.push_back(mk(3'd1, 8'hC3, 8'h80, 1, 1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 8'hE5, 1));
        vecs.push_back(mk(3'd1, 8'h82, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 8'h67, 1));
        vecs.push_back(mk(3'd2, 8'h00, 8'h00, 0, 0, 8'h0F, 8'hC0, 8'h00, 3'd0, 0, 8'hE7, 1));
        vecs.push_back(mk(3'd2, 8'h00, 8'h00, 0, 0, 8'h0F, 8'h01, 8'h00, 3'd0, 0, 8'h25, 1));
        vecs.push_back(mk(3'd3, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hFF, 3'd0, 0, 8'hEF, 1));
        vecs.push_back(mk(3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd3, 0, 8'hE6, 1));
        vecs.push_back(mk(3'd4, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd3, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd4, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd4, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd4, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd5, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd4, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd5, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd6, 0, 8'hAE, 1));
        vecs.push_back(mk(3'd4, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd6, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd1, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd7, 8'hFF, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd2, 1, 8'hEA, 1));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 1, 8'hEA, 0));
        vecs.push_back(mk(3'd6, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 8'hEE, 1));
        vecs.push_back(mk(3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd2, 0, 8'hEA, 1));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 1, 8'hEA, 0));
        vecs.push_back(mk(3'd6, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 1, 8'hEE, 1));
        vecs.push_back(mk(3'd3, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h30, 3'd0, 1, 8'h20, 1));
        vecs.push_back(mk(3'd0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 1, 8'h20, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            chk($sformatf("vec%0d_p", i), p_out, vecs[i].exp_p);
            chk($sformatf("vec%0d_irq", i), {7'd0, irq_mask}, {7'd0, vecs[i].exp_irq});
            chk($sformatf("vec%0d_carry", i), {7'd0, carry_to_alu}, {7'd0, vecs[i].exp_p[0]});
            chk($sformatf("vec%0d_dec", i), {7'd0, decimal}, {7'd0, vecs[i].exp_p[3]});
        end

        // Push image after loading all ones
        apply(mk(3'd3, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'hFF, 3'd0, 0, 8'hEF, 0));
        chk("load_ff_p", p_out, 8'hEF);
        idle_inputs();
        push_brk = 1'b1;
        #1;
        chk("push_brk1", p_push, 8'hFF);
        push_brk = 1'b0;
        #1;
        chk("push_brk0", p_push, 8'hEF);

        // Randomized traffic against the model; DUT state is EF, irq_mask 0 here
        m_p = 8'hEF;
        m_irq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            logic pb;
            v.sel = 3'($urandom_range(0, 7));
            v.mask = 8'($urandom);
            v.aluo = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            v.carry = 1'($urandom);
            v.ovf = 1'($urandom);
            v.a = 8'($urandom);
            v.mem = 8'($urandom);
            v.ld = 8'($urandom);
            v.idx = 3'($urandom);
            v.ie = ($urandom_range(0, 2) == 0);
            pb = 1'($urandom);
            push_brk = pb;
            model_step(v.sel, v.mask, v.aluo, v.carry, v.ovf, v.a, v.mem, v.ld, v.idx, v.ie);
            apply(v);
            chk($sformatf("rnd%0d_p", i), p_out, m_p);
            chk($sformatf("rnd%0d_irq", i), {7'd0, irq_mask}, {7'd0, m_irq});
            chk($sformatf("rnd%0d_push", i), p_push, {m_p[7:6], 1'b1, pb, m_p[3:0]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
